poets_block_id_fetcher: RTL and testbench
=========================================

// Module: poets_block_id_fetcher
// PURPOSE
//  Avalon-MM read master (initiator) for the per-block ID RAM (32x8 slave, 1-cycle read).
//  After reset, or on request, reads NUM_BYTES consecutive bytes from BASE_ADDR.
//  Assembles them little-endian into a stable block_id word for the streaming fabric.
//  Sits between the ID RAM's s1 slave port and the router/mailbox logic that tags packets.
// PARAMETERS
//  NUM_BYTES     4   ID width in bytes (1..8); block_id width = 8*NUM_BYTES
//  BASE_ADDR     0   first byte address in the ID RAM
//  ADDR_W        5   Avalon address width (byte-wide words)
//  READ_LATENCY  1   fixed slave read latency in cycles (1..4); 0 not supported
//  AUTO_START    1   1: fetch starts automatically after reset release; 0: wait for start
// PORTS
//  clk               in   1            system clock
//  reset_n           in   1            asynchronous active-low reset
//  start             in   1            pulse: (re)fetch ID; ignored while busy
//  avm_address       out  ADDR_W       byte address to ID RAM
//  avm_read          out  1            read request (also drives slave chipselect)
//  avm_waitrequest   in   1            slave stall; tie 0 for the MLAB RAM
//  avm_readdata      in   8            read data, valid READ_LATENCY cycles after accept
//  busy              out  1            fetch in progress
//  id_valid          out  1            block_id holds a completed, checked fetch
//  id_done           out  1            1-cycle pulse on fetch completion (pass or fail)
//  id_err            out  1            checksum mismatch on last fetch (0 without macro)
//  block_id          out  8*NUM_BYTES  assembled ID, byte k = addr BASE_ADDR+k at [8k+7:8k]
// BEHAVIOUR
//  Reset (async, any time, incl. mid-fetch): all outputs 0, state IDLE, in-flight read dropped.
//  FSM: IDLE -> REQ (on start, or first cycle after reset release if AUTO_START)
//       REQ: avm_read=1, address=BASE_ADDR+idx; accepted when avm_read & ~avm_waitrequest
//       REQ -> WAIT on accept; WAIT counts READ_LATENCY cycles, samples avm_readdata into
//       shadow byte idx on the final count; then idx+1 -> REQ, or last byte -> DONE
//       DONE: 1 cycle; commits shadow to block_id, pulses id_done -> IDLE.
//  One outstanding read only; avm_read and avm_address held stable while waitrequest=1.
//  Address arithmetic mod 2^ADDR_W (wraps past top of RAM, no error).
//  With READ_LATENCY=1, waitrequest=0: one byte per 2 cycles; 2*N+1 cycles start->id_done.
//  busy=1 from REQ entry through DONE; id_valid cleared on REQ entry, set in DONE on pass.
//  block_id updates only in DONE; holds previous value during refetch and on failure.
//  start while busy: ignored (no queuing). start in DONE cycle: ignored.
//  avm_read never asserted outside REQ; this block never writes the RAM.
// CONFIGURATION
//  Macro BLOCK_ID_CHECKSUM_EN:
//   defined: one extra read at BASE_ADDR+NUM_BYTES (checksum byte). In DONE, if checksum !=
//     XOR of all ID bytes: id_err=1, id_valid=0, block_id unchanged; else id_err=0 and commit.
//     id_err cleared on REQ entry. Fetch takes 2*(N+1)+1 cycles.
//   undefined: NUM_BYTES reads only; id_err tied 0; every completed fetch commits.
// STRUCTURE
//  Package poets_block_id_pkg: FSM state enum (IDLE/REQ/WAIT/DONE), ID_BYTE_W=8,
//   MAX_NUM_BYTES=8, MAX_READ_LATENCY=4, parameter defaults.
//  Sub-module poets_rd_latency_cnt: down-counter loaded on accept, flags sample cycle.
//  Byte index counter, shadow register, checksum XOR accumulator stay in top level.
// TESTING
//  1 Reset release, AUTO_START=1, RAM 0..3=11,22,33,44 -> addresses 0,1,2,3 read;
//    block_id=0x44332211, id_valid=1, id_done pulse at cycle 9.
//  2 avm_waitrequest=1 for 3 cycles on byte 2 -> address/read held stable, same
//    block_id, completion delayed by exactly 3 cycles.
//  3 READ_LATENCY=3, BASE_ADDR=30, NUM_BYTES=4 -> addresses 30,31,0,1 (wrap); data
//    sampled 3 cycles after each accept.
//  4 Completed fetch, RAM changed to AA.., start pulse, second start mid-fetch ->
//    id_valid low during refetch, old block_id held, second start ignored, then new ID.
//  5 reset_n asserted mid-byte-1 -> outputs 0 immediately; after release clean refetch.
//  6 BLOCK_ID_CHECKSUM_EN, byte4=0x44 vs XOR 0x44 -> pass; byte4=0x45 -> id_err=1,
//    id_valid=0, block_id unchanged.

Source files
------------

// File: rtl/poets_block_id_pkg.sv
// Shared types and limits for the block ID fetcher.
// Holds the fetch FSM encoding, byte/latency limits and the default parameter values.
package poets_block_id_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } fetch_state_t;

    localparam int ID_BYTE_W        = 8;
    localparam int MAX_NUM_BYTES    = 8;
    localparam int MAX_READ_LATENCY = 4;

    // Index must also reach NUM_BYTES for the optional checksum read.
    localparam int IDX_W     = $clog2(MAX_NUM_BYTES + 1);
    localparam int LAT_CNT_W = $clog2(MAX_READ_LATENCY);

    localparam int DEF_NUM_BYTES    = 4;
    localparam int DEF_BASE_ADDR    = 0;
    localparam int DEF_ADDR_W       = 5;
    localparam int DEF_READ_LATENCY = 1;
    localparam int DEF_AUTO_START   = 1;

endpackage

// File: rtl/poets_rd_latency_cnt.sv
// Read latency down-counter: loaded on read accept, flags the cycle readdata must be sampled.
// Latency: sample asserts on the READ_LATENCY-th active cycle after load; no backpressure.
// Backpressure: none; the caller only loads on an accepted read.
module poets_rd_latency_cnt
    import poets_block_id_pkg::*;
#(
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic active,
    output logic sample
);

    logic [LAT_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LAT_CNT_W'(READ_LATENCY - 1);
        end else if (active && (cnt != '0)) begin
            cnt <= cnt - LAT_CNT_W'(1);
        end
    end

    assign sample = active && (cnt == '0);

endmodule

// File: rtl/poets_block_id_fetcher.sv
// Avalon-MM read master fetching NUM_BYTES from the ID RAM into a little-endian block_id.
// Latency: reads*(1+READ_LATENCY) cycles from start to id_done; optional BLOCK_ID_CHECKSUM_EN adds a checksum byte.
// Backpressure: avm_waitrequest stalls the request with address/read held; start ignored while busy.
module poets_block_id_fetcher
    import poets_block_id_pkg::*;
#(
    parameter int NUM_BYTES    = DEF_NUM_BYTES,
    parameter int BASE_ADDR    = DEF_BASE_ADDR,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int AUTO_START   = DEF_AUTO_START
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    output logic [ADDR_W-1:0]              avm_address,
    output logic                           avm_read,
    input  logic                           avm_waitrequest,
    input  logic [ID_BYTE_W-1:0]           avm_readdata,
    output logic                           busy,
    output logic                           id_valid,
    output logic                           id_done,
    output logic                           id_err,
    output logic [ID_BYTE_W*NUM_BYTES-1:0] block_id
);

    localparam int ID_W = ID_BYTE_W * NUM_BYTES;
`ifdef BLOCK_ID_CHECKSUM_EN
    localparam int NUM_READS = NUM_BYTES + 1;
`else
    localparam int NUM_READS = NUM_BYTES;
`endif
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_READS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    fetch_state_t         state;
    logic [IDX_W-1:0]     idx;
    logic [ID_W-1:0]      shadow;
    logic [ID_W-1:0]      shadow_merged;
    logic                 auto_pend;
    logic                 accept;
    logic                 sample;
`ifdef BLOCK_ID_CHECKSUM_EN
    logic [ID_BYTE_W-1:0] xor_acc;
`endif

    assign accept = (state == REQ) && avm_read && !avm_waitrequest;

    poets_rd_latency_cnt #(
        .READ_LATENCY (READ_LATENCY)
    ) u_lat (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .active  (state == WAIT),
        .sample  (sample)
    );

    // Shadow with the byte arriving this cycle folded in, so the last byte commits without an extra cycle.
    always_comb begin
        shadow_merged = shadow;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (idx == IDX_W'(k)) begin
                shadow_merged[k*ID_BYTE_W +: ID_BYTE_W] = avm_readdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            shadow      <= '0;
            auto_pend   <= (AUTO_START != 0);
            avm_address <= '0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            id_valid    <= 1'b0;
            id_done     <= 1'b0;
            block_id    <= '0;
`ifdef BLOCK_ID_CHECKSUM_EN
            id_err      <= 1'b0;
            xor_acc     <= '0;
`endif
        end else begin
            id_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start || auto_pend) begin
                        state       <= REQ;
                        auto_pend   <= 1'b0;
                        idx         <= '0;
                        avm_address <= BASE;
                        avm_read    <= 1'b1;
                        busy        <= 1'b1;
                        id_valid    <= 1'b0;
`ifdef BLOCK_ID_CHECKSUM_EN
                        id_err      <= 1'b0;
                        xor_acc     <= '0;
`endif
                    end
                end
                REQ: begin
                    if (!avm_waitrequest) begin
                        avm_read <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (sample) begin
                        shadow <= shadow_merged;
`ifdef BLOCK_ID_CHECKSUM_EN
                        xor_acc <= xor_acc ^ avm_readdata;
`endif
                        if (idx == LAST_IDX) begin
                            state   <= DONE;
                            id_done <= 1'b1;
`ifdef BLOCK_ID_CHECKSUM_EN
                            // Final read is the checksum byte; shadow already holds every ID byte.
                            if (avm_readdata != xor_acc) begin
                                id_err <= 1'b1;
                            end else begin
                                block_id <= shadow;
                                id_valid <= 1'b1;
                            end
`else
                            block_id <= shadow_merged;
                            id_valid <= 1'b1;
`endif
                        end else begin
                            idx         <= idx + IDX_W'(1);
                            avm_address <= avm_address + ADDR_W'(1);
                            avm_read    <= 1'b1;
                            state       <= REQ;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef BLOCK_ID_CHECKSUM_EN
    assign id_err = 1'b0;
`endif

endmodule

// File: tb/tb_poets_block_id_fetcher.sv
// Scoreboard bench: stimulus queues expected reads/results, a negedge monitor pops and compares.
module tb_poets_block_id_fetcher;

`ifdef BLOCK_ID_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int N = 4;
    localparam int R = N + CS;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start0, start1, wr0, wr1;
    logic        rd0, rd1, busy0, busy1, val0, val1, done0, done1, err0, err1;
    logic [4:0]  addr0, addr1;
    logic [7:0]  rdata0, rdata1;
    logic [31:0] bid0, bid1;

    always #5 clk = ~clk;

    poets_block_id_fetcher #(
        .NUM_BYTES(4), .BASE_ADDR(0), .ADDR_W(5), .READ_LATENCY(1), .AUTO_START(1)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0),
        .avm_address(addr0), .avm_read(rd0), .avm_waitrequest(wr0), .avm_readdata(rdata0),
        .busy(busy0), .id_valid(val0), .id_done(done0), .id_err(err0), .block_id(bid0)
    );

    poets_block_id_fetcher #(
        .NUM_BYTES(4), .BASE_ADDR(30), .ADDR_W(5), .READ_LATENCY(3), .AUTO_START(0)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1),
        .avm_address(addr1), .avm_read(rd1), .avm_waitrequest(wr1), .avm_readdata(rdata1),
        .busy(busy1), .id_valid(val1), .id_done(done1), .id_err(err1), .block_id(bid1)
    );

    // ID RAM slave model: data valid only exactly READ_LATENCY cycles after accept, 0xEE otherwise.
    logic [7:0] ram [32];
    logic [8:0] p0;
    logic [8:0] p1 [3];

    always @(posedge clk) begin
        p0    <= {rd0 & ~wr0, ram[addr0]};
        p1[0] <= {rd1 & ~wr1, ram[addr1]};
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign rdata0 = p0[8] ? p0[7:0] : 8'hEE;
    assign rdata1 = p1[2][8] ? p1[2][7:0] : 8'hEE;

    int cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct { int d; logic [4:0] a; } addr_t;
    typedef struct { int d; logic [31:0] bid; logic v; logic e; int c; } res_t;
    addr_t aq[$];
    res_t  rq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    logic       ps0 = 1'b0, ps1 = 1'b0;
    logic [4:0] pa0 = '0, pa1 = '0;

    task automatic mon(input int d, input logic rd, input logic wr, input logic [4:0] a,
                       input logic dn, input logic [31:0] b, input logic v, input logic e,
                       inout logic ps, inout logic [4:0] pa);
        addr_t x;
        res_t  r;
        if (ps) begin
            chk("stall_read_held", 64'(rd), 64'(1));
            chk("stall_addr_held", 64'(a), 64'(pa));
        end
        ps = rd && wr;
        pa = a;
        if (rd && !wr) begin
            chk("read_expected", 64'(aq.size() > 0), 64'(1));
            if (aq.size() > 0) begin
                x = aq.pop_front();
                chk("read_dut", 64'(d), 64'(x.d));
                chk("read_addr", 64'(a), 64'(x.a));
            end
        end
        if (dn) begin
            chk("done_expected", 64'(rq.size() > 0), 64'(1));
            if (rq.size() > 0) begin
                r = rq.pop_front();
                chk("done_dut", 64'(d), 64'(r.d));
                chk("block_id", 64'(b), 64'(r.bid));
                chk("id_valid", 64'(v), 64'(r.v));
                chk("id_err", 64'(e), 64'(r.e));
                chk("done_cycle", 64'(cyc), 64'(r.c));
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            mon(0, rd0, wr0, addr0, done0, bid0, val0, err0, ps0, pa0);
            mon(1, rd1, wr1, addr1, done1, bid1, val1, err1, ps1, pa1);
        end else begin
            ps0 = 1'b0;
            ps1 = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input int d, input logic [4:0] base, input int nreads);
        addr_t x;
        for (int i = 0; i < nreads; i++) begin
            x.d = d;
            x.a = base + 5'(i);
            aq.push_back(x);
        end
    endtask

    task automatic push_res(input int d, input logic [31:0] bid, input logic v, input logic e, input int c);
        res_t r;
        r.d = d; r.bid = bid; r.v = v; r.e = e; r.c = c;
        rq.push_back(r);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((aq.size() != 0 || rq.size() != 0 || busy0 || busy1) && k < budget) begin
            tick(1);
            k++;
        end
        chk("completed_in_budget",
            64'(aq.size() == 0 && rq.size() == 0 && !busy0 && !busy1), 64'(1));
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int e;
        reset_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
        for (int i = 0; i < 32; i++) ram[i] = 8'(i * 7 + 3);
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44; ram[4] = 8'h44;
        ram[30] = 8'h5A; ram[31] = 8'hC3;
        tick(2);
        chk("reset_outputs_dut0", 64'({busy0, val0, done0, err0, rd0, addr0, bid0}), 64'(0));
        chk("reset_outputs_dut1", 64'({busy1, val1, done1, err1, rd1, addr1, bid1}), 64'(0));

        // 1: auto-start after reset release
        push_fetch(0, 5'd0, R);
        push_res(0, 32'h44332211, 1'b1, 1'b0, 2 * R + 1);
        reset_n = 1'b1;
        wait_idle(100);

        // 2: three waitrequest cycles on byte 2
        e = cyc + 1;
        push_fetch(0, 5'd0, R);
        push_res(0, 32'h44332211, 1'b1, 1'b0, e + 2 * R + 3);
        start0 = 1'b1; tick(1); start0 = 1'b0;
        tick(4);
        wr0 = 1'b1;
        tick(3);
        wr0 = 1'b0;
        wait_idle(100);

        // 3: latency 3, base 30, address wrap (checksum byte at 2 mismatches 0xAA)
        e = cyc + 1;
        push_fetch(1, 5'd30, R);
        if (CS != 0) push_res(1, 32'h0, 1'b0, 1'b1, e + 4 * R);
        else         push_res(1, 32'h2211C35A, 1'b1, 1'b0, e + 4 * R);
        start1 = 1'b1; tick(1); start1 = 1'b0;
        wait_idle(200);

        // 4: refetch with new contents, start mid-fetch and in DONE ignored
        ram[0] = 8'hAA; ram[1] = 8'hBB; ram[2] = 8'hCC; ram[3] = 8'hDD; ram[4] = 8'h00;
        e = cyc + 1;
        push_fetch(0, 5'd0, R);
        push_res(0, 32'hDDCCBBAA, 1'b1, 1'b0, e + 2 * R);
        start0 = 1'b1; tick(1); start0 = 1'b0;
        tick(2);
        chk("refetch_valid_low", 64'(val0), 64'(0));
        chk("refetch_bid_held", 64'(bid0), 64'(32'h44332211));
        chk("refetch_busy", 64'(busy0), 64'(1));
        start0 = 1'b1; tick(1); start0 = 1'b0;
        tick(2 * R - 3);
        start0 = 1'b1; tick(1); start0 = 1'b0;
        wait_idle(100);
        chk("start_in_done_ignored", 64'(busy0), 64'(0));

        // 5: reset during byte 1, then clean auto refetch
        push_fetch(0, 5'd0, 2);
        start0 = 1'b1; tick(1); start0 = 1'b0;
        tick(3);
        reset_n = 1'b0;
        #1;
        chk("midfetch_reset_outputs", 64'({busy0, val0, done0, err0, rd0, addr0, bid0}), 64'(0));
        chk("midfetch_reset_addr_q", 64'(aq.size()), 64'(0));
        tick(2);
        push_fetch(0, 5'd0, R);
        push_res(0, 32'hDDCCBBAA, 1'b1, 1'b0, 2 * R + 1);
        reset_n = 1'b1;
        wait_idle(100);

`ifdef BLOCK_ID_CHECKSUM_EN
        // 6: checksum pass then fail
        ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44; ram[4] = 8'h44;
        e = cyc + 1;
        push_fetch(0, 5'd0, R);
        push_res(0, 32'h44332211, 1'b1, 1'b0, e + 2 * R);
        start0 = 1'b1; tick(1); start0 = 1'b0;
        wait_idle(100);
        ram[4] = 8'h45;
        e = cyc + 1;
        push_fetch(0, 5'd0, R);
        push_res(0, 32'h44332211, 1'b0, 1'b1, e + 2 * R);
        start0 = 1'b1; tick(1); start0 = 1'b0;
        wait_idle(100);
        chk("csum_fail_valid_low", 64'(val0), 64'(0));
`endif

        chk("addr_queue_empty", 64'(aq.size()), 64'(0));
        chk("result_queue_empty", 64'(rq.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
